// File: rtl/calc_sequencer.sv
// Calculator sequencer: builds operands A/B from hex key pulses, latches the operator,
// runs the ALU start/done handshake and drives the display value and error flag.
module calc_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             num_pressed,
    input  logic             op_pressed,
    input  logic [3:0]       hex,
    input  logic [3:0]       operator,
    output logic             alu_start,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_error,
    output logic [WIDTH-1:0] disp_value,
    output logic             disp_error,
    output logic             busy
);

    localparam int unsigned MaxDigits = WIDTH / 4;
    localparam int unsigned CntW      = $clog2(MaxDigits + 1);
    localparam int unsigned TmoW      = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StEnterA,
        StOp,
        StEnterB,
        StExec,
        StWait,
        StResult,
        StError
    } state_e;

    state_e            state;
    logic [CntW-1:0]   digit_cnt;
    logic [TmoW-1:0]   tmo_cnt;

    logic              is_arith;
    logic              is_equals;
    logic              is_clear;
    logic              is_digit;
    logic              can_shift;
    logic [WIDTH-1:0]  a_shift;
    logic [WIDTH-1:0]  b_shift;
    logic [WIDTH-1:0]  hex_ext;

    // An operator key always masks a digit key arriving in the same cycle.
    assign is_arith  = op_pressed && (operator >= 4'd1) && (operator <= 4'd4);
    assign is_equals = op_pressed && (operator == 4'hE);
    assign is_clear  = op_pressed && (operator == 4'hF);
    assign is_digit  = num_pressed && !op_pressed;
    assign can_shift = digit_cnt < CntW'(MaxDigits);
    assign a_shift   = {alu_a[WIDTH-5:0], hex};
    assign b_shift   = {alu_b[WIDTH-5:0], hex};
    assign hex_ext   = WIDTH'(hex);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= StEnterA;
            digit_cnt  <= '0;
            tmo_cnt    <= '0;
            alu_start  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            disp_value <= '0;
            disp_error <= 1'b0;
            busy       <= 1'b0;
        end else if (is_clear && (state != StExec)) begin
            state      <= StEnterA;
            digit_cnt  <= '0;
            tmo_cnt    <= '0;
            alu_start  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            disp_value <= '0;
            disp_error <= 1'b0;
            busy       <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            unique case (state)
                StEnterA: begin
                    if (is_arith) begin
                        alu_op <= operator;
                        state  <= StOp;
                    end else if (is_digit && can_shift) begin
                        alu_a      <= a_shift;
                        disp_value <= a_shift;
                        digit_cnt  <= digit_cnt + CntW'(1);
                    end
                end
                StOp: begin
                    if (is_arith) begin
                        alu_op <= operator;
                    end else if (is_digit) begin
                        alu_b      <= hex_ext;
                        disp_value <= hex_ext;
                        digit_cnt  <= CntW'(1);
                        state      <= StEnterB;
                    end
                end
                StEnterB: begin
                    if (is_arith) begin
                        alu_op <= operator;
                    end else if (is_equals) begin
                        alu_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= StExec;
                    end else if (is_digit && can_shift) begin
                        alu_b      <= b_shift;
                        disp_value <= b_shift;
                        digit_cnt  <= digit_cnt + CntW'(1);
                    end
                end
                StExec: begin
                    tmo_cnt <= '0;
                    state   <= StWait;
                end
                StWait: begin
                    if (alu_done) begin
                        busy <= 1'b0;
                        if (alu_error) begin
                            disp_error <= 1'b1;
                            disp_value <= '0;
                            state      <= StError;
                        end else begin
                            disp_value <= alu_result;
                            state      <= StResult;
                        end
                    end else if (tmo_cnt == TmoW'(TIMEOUT - 1)) begin
                        busy       <= 1'b0;
                        disp_error <= 1'b1;
                        disp_value <= '0;
                        state      <= StError;
                    end else begin
                        tmo_cnt <= tmo_cnt + TmoW'(1);
                    end
                end
                StResult: begin
                    // disp_value holds the last result here, so chaining reuses it as A.
                    if (is_arith) begin
                        alu_a  <= disp_value;
                        alu_op <= operator;
                        state  <= StOp;
                    end else if (is_digit) begin
                        alu_a      <= hex_ext;
                        disp_value <= hex_ext;
                        digit_cnt  <= CntW'(1);
                        state      <= StEnterA;
                    end
                end
                StError: begin
                end
                default: state <= StEnterA;
            endcase
        end
    end

endmodule
